// File: rtl/vga_bus_arbiter.sv
// Two-port round-robin owner of the VGA (ISA-style) bus. Each granted request runs one
// complete bus cycle: address/BALE setup, command strobe (WAIT-stretched for memory),
// hold, then recovery before the next grant. All bus outputs are registered.
module vga_bus_arbiter #(
    parameter int unsigned SETUP_CYC   = 3,
    parameter int unsigned CMD_CYC     = 3,
    parameter int unsigned HOLD_CYC    = 2,
    parameter int unsigned RECOVER_CYC = 2,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic        mclk,
    input  logic        reset,
    input  logic        req0,
    input  logic        io0,
    input  logic        rw0,
    input  logic        sa00,
    input  logic        sa120,
    input  logic [15:0] wdata0,
    input  logic        req1,
    input  logic        io1,
    input  logic        rw1,
    input  logic        sa01,
    input  logic        sa121,
    input  logic [15:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] rdata,
    output logic        err,
    output logic        BALE,
    output logic        IOR,
    output logic        IOW,
    output logic        MEMR,
    output logic        MEMW,
    output logic        SA0,
    output logic        SA12,
    output logic [15:0] DG_OUT,
    output logic        DG_OE,
    input  logic [15:0] DG_IN,
    input  logic        WAIT
);

    // Phase lengths must fit the 8-bit phase counter.
    localparam int unsigned CW = 8;
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {StIdle, StSetup, StCmd, StHold, StRecover} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic          port_q, port_d;
    logic          last_q, last_d;
    logic          io_q, io_d;
    logic          rw_q, rw_d;
    logic          abort_q, abort_d;
    logic          bale_q, bale_d;
    logic [3:0]    strb_q, strb_d;   // active-low {MEMW, MEMR, IOW, IOR}
    logic          sa0_q, sa0_d;
    logic          sa12_q, sa12_d;
    logic [15:0]   dg_out_q, dg_out_d;
    logic          dg_oe_q, dg_oe_d;
    logic [15:0]   rdata_q, rdata_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    done_q, done_d;
    logic          err_q, err_d;
    logic          pick;
    logic [3:0]    strb_sel;

    // Next-state: arbitration in idle, then the fixed phase sequence of one bus cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wcnt_d   = wcnt_q;
        port_d   = port_q;
        last_d   = last_q;
        io_d     = io_q;
        rw_d     = rw_q;
        abort_d  = abort_q;
        bale_d   = bale_q;
        strb_d   = strb_q;
        sa0_d    = sa0_q;
        sa12_d   = sa12_q;
        dg_out_d = dg_out_q;
        dg_oe_d  = dg_oe_q;
        rdata_d  = rdata_q;
        gnt_d    = 2'b00;
        done_d   = 2'b00;
        err_d    = 1'b0;
        pick     = 1'b0;
        strb_sel = io_q ? (rw_q ? 4'b1110 : 4'b1101) : (rw_q ? 4'b1011 : 4'b0111);

        case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    // With both requesting, the port not granted last wins.
                    pick     = (req0 && req1) ? ~last_q : req1;
                    port_d   = pick;
                    last_d   = pick;
                    gnt_d    = pick ? 2'b10 : 2'b01;
                    io_d     = pick ? io1 : io0;
                    rw_d     = pick ? rw1 : rw0;
                    sa0_d    = pick ? sa01 : sa00;
                    sa12_d   = pick ? sa121 : sa120;
                    dg_out_d = pick ? wdata1 : wdata0;
                    dg_oe_d  = ~(pick ? rw1 : rw0);
                    bale_d   = 1'b0;
                    abort_d  = 1'b0;
                    wcnt_d   = '0;
                    cnt_d    = CW'(SETUP_CYC - 1);
                    state_d  = StSetup;
                end
            end
            StSetup: begin
                if (cnt_q == '0) begin
                    strb_d  = strb_sel;
                    cnt_d   = CW'(CMD_CYC - 1);
                    state_d = StCmd;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StCmd: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (io_q || WAIT) begin
                    strb_d  = 4'b1111;
                    if (rw_q) begin
                        rdata_d = DG_IN;
                    end
                    cnt_d   = CW'(HOLD_CYC - 1);
                    state_d = StHold;
                end else if (wcnt_q == WW'(TIMEOUT)) begin
                    // Memory never became ready: finish the cycle with an error.
                    strb_d  = 4'b1111;
                    rdata_d = 16'hFFFF;
                    abort_d = 1'b1;
                    cnt_d   = CW'(HOLD_CYC - 1);
                    state_d = StHold;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    done_d  = port_q ? 2'b10 : 2'b01;
                    err_d   = abort_q;
                    bale_d  = 1'b1;
                    sa0_d   = 1'b1;
                    sa12_d  = 1'b1;
                    dg_oe_d = 1'b0;
                    cnt_d   = CW'(RECOVER_CYC - 1);
                    state_d = StRecover;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StRecover: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset returns the bus to idle and drops any cycle.
    always_ff @(posedge mclk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            wcnt_q   <= '0;
            port_q   <= 1'b0;
            last_q   <= 1'b1;
            io_q     <= 1'b0;
            rw_q     <= 1'b0;
            abort_q  <= 1'b0;
            bale_q   <= 1'b1;
            strb_q   <= 4'b1111;
            sa0_q    <= 1'b1;
            sa12_q   <= 1'b1;
            dg_out_q <= 16'h0000;
            dg_oe_q  <= 1'b0;
            rdata_q  <= 16'hFFFF;
            gnt_q    <= 2'b00;
            done_q   <= 2'b00;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wcnt_q   <= wcnt_d;
            port_q   <= port_d;
            last_q   <= last_d;
            io_q     <= io_d;
            rw_q     <= rw_d;
            abort_q  <= abort_d;
            bale_q   <= bale_d;
            strb_q   <= strb_d;
            sa0_q    <= sa0_d;
            sa12_q   <= sa12_d;
            dg_out_q <= dg_out_d;
            dg_oe_q  <= dg_oe_d;
            rdata_q  <= rdata_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign gnt0   = gnt_q[0];
    assign gnt1   = gnt_q[1];
    assign done0  = done_q[0];
    assign done1  = done_q[1];
    assign err    = err_q;
    assign rdata  = rdata_q;
    assign BALE   = bale_q;
    assign IOR    = strb_q[0];
    assign IOW    = strb_q[1];
    assign MEMR   = strb_q[2];
    assign MEMW   = strb_q[3];
    assign SA0    = sa0_q;
    assign SA12   = sa12_q;
    assign DG_OUT = dg_out_q;
    assign DG_OE  = dg_oe_q;

endmodule
